// File: rtl/sized_data_memory.sv
// Byte-addressed big-endian data memory with byte/half/word accesses,
// one-cycle registered reads and a sticky first-fault capture with a saturating fault counter.
module sized_data_memory #(
  parameter int DM_BYTES    = 1024,
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   MemoryRead,
  input  logic                   MemoryWrite,
  input  logic [1:0]             Size,
  input  logic                   Unsigned,
  input  logic [31:0]            Address,
  input  logic [31:0]            InputData,
  output logic [31:0]            OutputData,
  output logic                   ReadValid,
  output logic                   Fault,
  output logic [31:0]            FaultAddress,
  output logic [FAULT_CNT_W-1:0] FaultCount,
  input  logic                   ClearFault
);

  localparam int          AW    = $clog2(DM_BYTES);
  localparam logic [32:0] LIMIT = 33'(DM_BYTES);

  logic [7:0] mem [DM_BYTES];

  logic                   req_s, misalign_s, bad_s, fault_s, rd_ok_s, wr_ok_s;
  logic [32:0]            span_s, last_s;
  logic [AW-1:0]          idx_s;
  logic [7:0]             b0_s, b1_s, b2_s, b3_s;
  logic [31:0]            rd_field_s;
  logic [3:0]             wen_s;
  logic [7:0]             wbyte_s [4];

  logic [31:0]            out_d, out_q;
  logic                   rv_d, rv_q, fault_d, fault_q, held_d, held_q;
  logic [31:0]            faddr_d, faddr_q;
  logic [FAULT_CNT_W-1:0] fcnt_d, fcnt_q;

  // Request classification; the range check is done in 33 bits so high addresses cannot wrap.
  always_comb begin
    req_s      = MemoryRead | MemoryWrite;
    span_s     = 33'd0;
    misalign_s = 1'b0;
    case (Size)
      2'b00: begin span_s = 33'd0; misalign_s = 1'b0;              end
      2'b01: begin span_s = 33'd1; misalign_s = Address[0];        end
      2'b10: begin span_s = 33'd3; misalign_s = |Address[1:0];     end
      default: begin span_s = 33'd0; misalign_s = 1'b1;            end
    endcase
    last_s  = {1'b0, Address} + span_s;
    bad_s   = (MemoryRead & MemoryWrite) | misalign_s | (last_s >= LIMIT);
    fault_s = req_s & bad_s;
    rd_ok_s = MemoryRead & ~bad_s;
    wr_ok_s = MemoryWrite & ~bad_s;
  end

  assign idx_s = Address[AW-1:0];
  assign b0_s  = mem[idx_s];
  assign b1_s  = mem[idx_s + AW'(1)];
  assign b2_s  = mem[idx_s + AW'(2)];
  assign b3_s  = mem[idx_s + AW'(3)];

  // Big-endian field assembly and extension for reads.
  always_comb begin
    rd_field_s = 32'h0000_0000;
    case (Size)
      2'b00:   rd_field_s = Unsigned ? {24'h00_0000, b0_s} : {{24{b0_s[7]}}, b0_s};
      2'b01:   rd_field_s = Unsigned ? {16'h0000, b0_s, b1_s} : {{16{b0_s[7]}}, b0_s, b1_s};
      2'b10:   rd_field_s = {b0_s, b1_s, b2_s, b3_s};
      default: rd_field_s = 32'h0000_0000;
    endcase
  end

  // Byte-lane enables and data for writes; lane k lands at Address+k.
  always_comb begin
    wen_s = 4'b0000;
    for (int k = 0; k < 4; k++) wbyte_s[k] = 8'h00;
    case (Size)
      2'b00: begin
        wen_s      = {3'b000, wr_ok_s};
        wbyte_s[0] = InputData[7:0];
      end
      2'b01: begin
        wen_s      = {2'b00, {2{wr_ok_s}}};
        wbyte_s[0] = InputData[15:8];
        wbyte_s[1] = InputData[7:0];
      end
      2'b10: begin
        wen_s      = {4{wr_ok_s}};
        wbyte_s[0] = InputData[31:24];
        wbyte_s[1] = InputData[23:16];
        wbyte_s[2] = InputData[15:8];
        wbyte_s[3] = InputData[7:0];
      end
      default: wen_s = 4'b0000;
    endcase
  end

  // Memory array is deliberately not reset; requests are ignored while resetn is low.
  always_ff @(posedge clock) begin
    if (resetn) begin
      for (int k = 0; k < 4; k++) begin
        if (wen_s[k]) mem[idx_s + AW'(k)] <= wbyte_s[k];
      end
    end
  end

  // Next-state for read data, pulses and fault bookkeeping; a fault outranks ClearFault.
  always_comb begin
    out_d   = out_q;
    rv_d    = rd_ok_s;
    fault_d = fault_s;
    held_d  = held_q;
    faddr_d = faddr_q;
    fcnt_d  = fcnt_q;
    if (rd_ok_s) begin
      out_d = rd_field_s;
    end else begin
      out_d = out_q;
    end
    if (fault_s) begin
      held_d = 1'b1;
      if (ClearFault) begin
        fcnt_d = FAULT_CNT_W'(1'b1);
      end else if (&fcnt_q) begin
        fcnt_d = fcnt_q;
      end else begin
        fcnt_d = fcnt_q + FAULT_CNT_W'(1'b1);
      end
      if (ClearFault || !held_q) begin
        faddr_d = Address;
      end else begin
        faddr_d = faddr_q;
      end
    end else if (ClearFault) begin
      held_d  = 1'b0;
      faddr_d = 32'h0000_0000;
      fcnt_d  = {FAULT_CNT_W{1'b0}};
    end else begin
      held_d  = held_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_q   <= 32'h0000_0000;
      rv_q    <= 1'b0;
      fault_q <= 1'b0;
      held_q  <= 1'b0;
      faddr_q <= 32'h0000_0000;
      fcnt_q  <= {FAULT_CNT_W{1'b0}};
    end else begin
      out_q   <= out_d;
      rv_q    <= rv_d;
      fault_q <= fault_d;
      held_q  <= held_d;
      faddr_q <= faddr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign OutputData   = out_q;
  assign ReadValid    = rv_q;
  assign Fault        = fault_q;
  assign FaultAddress = faddr_q;
  assign FaultCount   = fcnt_q;

endmodule

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 SHALL have parameter DM_BYTES, default 1024, meaning memory size in bytes; power of two, at least 8.
REQ-002 SHALL have parameter FAULT_CNT_W, default 8, meaning width of the saturating fault counter.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port MemoryRead, input, 1, read request this cycle.
REQ-006 SHALL have port MemoryWrite, input, 1, write request this cycle.
REQ-007 SHALL have port Size, input, 2, access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port Unsigned, input, 1, read extension: 1 zero-extend, 0 sign-extend; ignored for word and write accesses.
REQ-009 SHALL have port Address, input, 32, byte address.
REQ-010 SHALL have port InputData, input, 32, write data; field right-aligned (byte [7:0], half [15:0]).
REQ-011 SHALL have port OutputData, output, 32, registered read data.
REQ-012 SHALL have port ReadValid, output, 1, one-cycle pulse marking new OutputData.
REQ-013 SHALL have port Fault, output, 1, one-cycle pulse for a rejected request.
REQ-014 SHALL have port FaultAddress, output, 32, Address of the first fault since reset or clear.
REQ-015 SHALL have port FaultCount, output, FAULT_CNT_W, saturating count of faults.
REQ-016 SHALL have port ClearFault, input, 1, clears FaultAddress capture and FaultCount.

Function
REQ-017 SHALL evaluate a request at each rising edge where resetn=1 and MemoryRead or MemoryWrite is 1.
REQ-018 SHALL classify a request as faulting on any of: both MemoryRead and MemoryWrite set; Size=11; halfword with Address[0]=1; word with Address[1:0]!=00; Address+size-1 >= DM_BYTES.
REQ-019 SHALL store big-endian: the most significant byte of the written field goes to Address, the following bytes to Address+1 and onward.
REQ-020 SHALL on a valid write update exactly 1, 2 or 4 bytes for byte, half or word; no other byte changes.
REQ-021 SHALL on a valid read load OutputData at the same edge with the big-endian field, extended per Unsigned, and pulse ReadValid high for the following cycle; read latency is one cycle.
REQ-022 SHALL hold OutputData unchanged when no valid read is accepted, including after writes and faults.
REQ-023 SHALL give a read issued the cycle after a write to an overlapping byte the newly written data.
REQ-024 SHALL on a faulting request suppress any memory update, leave OutputData unchanged, keep ReadValid 0, and pulse Fault high for the following cycle.
REQ-025 SHALL capture Address into FaultAddress only on the first fault while no capture is held; later faults do not overwrite it.
REQ-026 SHALL increment FaultCount by one per fault and saturate at all-ones.
REQ-027 SHALL on ClearFault=1 clear the capture and set FaultCount to 0; a fault in the same cycle wins, recording FaultAddress and setting FaultCount to 1.
REQ-028 SHALL not reject on ClearFault; it is independent of the request path.

Reset
REQ-029 SHALL on resetn=0 at a rising edge set OutputData=0, ReadValid=0, Fault=0, FaultAddress=0, FaultCount=0 and clear the capture.
REQ-030 SHALL ignore requests during reset and SHALL NOT clear memory contents on reset.
REQ-031 SHALL drop a ReadValid or Fault pulse due next cycle if reset is asserted mid-operation; outputs show reset values instead.

Verification
REQ-032 Word write 0x11223344 at 0x10, then byte read at 0x11 with Unsigned=0 -> OutputData=0x00000022 with ReadValid one cycle later.
REQ-033 Halfword write 0x0000F00D at 0x20, halfword read at 0x20 with Unsigned=0 -> 0xFFFFF00D; with Unsigned=1 -> 0x0000F00D.
REQ-034 Word read at 0x02 -> Fault pulse, FaultAddress=0x2, FaultCount=1, OutputData unchanged; then a word write at DM_BYTES-2 -> second Fault, FaultAddress stays 0x2, FaultCount=2, memory unchanged.
REQ-035 MemoryRead and MemoryWrite both 1 at 0x30 -> Fault, no write; subsequent read at 0x30 returns the prior content.
REQ-036 With FAULT_CNT_W=2, five faults -> FaultCount=3; ClearFault together with a fault at 0x40 -> FaultCount=1, FaultAddress=0x40.
REQ-037 Write 0xAABBCCDD at 0x0, assert resetn=0 for one edge with a read pending -> OutputData=0, no ReadValid; read at 0x0 after reset -> 0xAABBCCDD.
